soundpath_sched: RTL and testbench

Round scheduler for NUM_PATHS parallel soundpath instances.
- Generates the shared per-sample strobe.
- Double-buffers each path's mode/divisor so that configuration changes land only on sample boundaries (no mid-period glitches).
- Collects each path's done/sample with a timeout.
- Mixes the results into one 8-bit sample for the PWM stage.

---
 rtl/soundpath_pkg.sv | 9 +
 rtl/sample_ticker.sv | 21 ++
 rtl/soundpath_sched.sv | 148 ++++++++++++++
 tb/tb_soundpath_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soundpath_pkg.sv
// soundpath_pkg: shared types and widths for the soundpath scheduler
// Provides the waveform mode encoding, the scheduler state encoding and the
// divisor/sample widths used by soundpath_sched and its helpers.
package soundpath_pkg;
    localparam int DIV_W    = 19;
    localparam int SAMPLE_W = 8;
    typedef enum logic [1:0] {OFF, SQUARE, SAW, TRI} mode_t;
    typedef enum logic [2:0] {IDLE, COMMIT, FIRE, WAIT, MIX} sched_state_t;
endpackage

// File: rtl/sample_ticker.sv
// sample_ticker: free-running modulo-DIV counter with a one-cycle tick on the last count
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset (counter back to 0)
//   tick - high while the count equals DIV-1
module sample_ticker #(
    parameter int DIV = 250
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = cnt_q == CW'(DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/soundpath_sched.sv
// soundpath_sched: per-sample round scheduler, config double-buffer and mixer for NUM_PATHS soundpaths
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   cfg_we/cfg_sel     - write one path's shadow mode/divisor (cfg_mode, cfg_divisor)
//   path_done          - per-path completion (pulse or level)
//   path_sample        - packed per-path samples, path i at [8i+7:8i]
//   sample_now         - one-cycle strobe to all soundpaths
//   path_mode          - committed mode per path (2 bits each)
//   path_divisor       - committed divisor per path (19 bits each)
//   mix_sample         - mixed sample, held between rounds
//   mix_valid          - one-cycle pulse when mix_sample updates
//   timeout_err        - pulses with mix_valid when the round was force-closed
// Build option MIX_SAT_EN: saturating sum instead of averaging shift.
module soundpath_sched
    import soundpath_pkg::*;
#(
    parameter int NUM_PATHS  = 4,
    parameter int SAMPLE_DIV = 250,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_PATHS)-1:0]  cfg_sel,
    input  logic [1:0]                    cfg_mode,
    input  logic [DIV_W-1:0]              cfg_divisor,
    input  logic [NUM_PATHS-1:0]          path_done,
    input  logic [SAMPLE_W*NUM_PATHS-1:0] path_sample,
    output logic                          sample_now,
    output logic [2*NUM_PATHS-1:0]        path_mode,
    output logic [DIV_W*NUM_PATHS-1:0]    path_divisor,
    output logic [SAMPLE_W-1:0]           mix_sample,
    output logic                          mix_valid,
    output logic                          timeout_err
);
    localparam int LG     = $clog2(NUM_PATHS);
    localparam int SUM_W  = SAMPLE_W + LG;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT + 4 >= SAMPLE_DIV) begin : g_bad_timeout
        $error("soundpath_sched: TIMEOUT+4 must be below SAMPLE_DIV");
    end
    if (NUM_PATHS < 2 || NUM_PATHS > 8 || (NUM_PATHS & (NUM_PATHS - 1)) != 0) begin : g_bad_paths
        $error("soundpath_sched: NUM_PATHS must be a power of two in 2..8");
    end

    sched_state_t         state_q;
    mode_t                shadow_mode_q [NUM_PATHS];
    logic [DIV_W-1:0]     shadow_div_q  [NUM_PATHS];
    logic [SAMPLE_W-1:0]  lat_q         [NUM_PATHS];
    logic [NUM_PATHS-1:0] active_q, got_q, got_d;
    logic [WCNT_W-1:0]    wcnt_q;
    logic                 to_flag_q;
    logic                 tick;
    logic [SUM_W-1:0]     sum;
    logic [SAMPLE_W-1:0]  mix_d;

    sample_ticker #(.DIV(SAMPLE_DIV)) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Shadow writes land immediately; live copies only move in COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PATHS; i++) begin
                shadow_mode_q[i] <= OFF;
                shadow_div_q[i]  <= DIV_W'(1);
            end
        end else if (cfg_we && int'(cfg_sel) < NUM_PATHS) begin
            shadow_mode_q[cfg_sel] <= mode_t'(cfg_mode);
            shadow_div_q[cfg_sel]  <= cfg_divisor;
        end
    end

    // Only the first done of an active path counts; got_q gates both latching and the mix.
    always_comb begin
        got_d = got_q | (active_q & path_done);
        sum   = '0;
        for (int i = 0; i < NUM_PATHS; i++) sum += got_q[i] ? SUM_W'(lat_q[i]) : '0;
    end

`ifdef MIX_SAT_EN
    assign mix_d = (sum > SUM_W'(255)) ? 8'hff : sum[SAMPLE_W-1:0];
`else
    assign mix_d = SAMPLE_W'(sum >> LG);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_now   <= 1'b0;
            mix_sample   <= '0;
            mix_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            path_mode    <= '0;
            active_q     <= '0;
            got_q        <= '0;
            wcnt_q       <= '0;
            to_flag_q    <= 1'b0;
            for (int i = 0; i < NUM_PATHS; i++) begin
                path_divisor[DIV_W*i +: DIV_W] <= DIV_W'(1);
                lat_q[i] <= '0;
            end
        end else begin
            sample_now  <= 1'b0;
            mix_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (state_q)
                IDLE: if (tick) state_q <= COMMIT;
                COMMIT: begin
                    for (int i = 0; i < NUM_PATHS; i++) begin
                        path_mode[2*i +: 2]            <= shadow_mode_q[i];
                        path_divisor[DIV_W*i +: DIV_W] <= shadow_div_q[i];
                        active_q[i]                    <= shadow_mode_q[i] != OFF;
                        lat_q[i]                       <= '0;
                    end
                    got_q      <= '0;
                    wcnt_q     <= '0;
                    to_flag_q  <= 1'b0;
                    sample_now <= 1'b1;
                    state_q    <= FIRE;
                end
                FIRE: state_q <= WAIT;
                WAIT: begin
                    got_q  <= got_d;
                    wcnt_q <= wcnt_q + WCNT_W'(1);
                    for (int i = 0; i < NUM_PATHS; i++)
                        if (got_d[i] && !got_q[i]) lat_q[i] <= path_sample[SAMPLE_W*i +: SAMPLE_W];
                    if ((got_d & active_q) == active_q) begin
                        state_q <= MIX;
                    end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        to_flag_q <= 1'b1;
                        state_q   <= MIX;
                    end
                end
                MIX: begin
                    mix_sample  <= mix_d;
                    mix_valid   <= 1'b1;
                    timeout_err <= to_flag_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soundpath_sched.sv
// tb_soundpath_sched: randomized self-checking bench against a round-level reference model
module tb_soundpath_sched;
    import soundpath_pkg::*;
    localparam int NP = 4;
    localparam int SD = 250;
    localparam int TO = 64;
    localparam int LG = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [LG-1:0]        cfg_sel = '0;
    logic [1:0]           cfg_mode = '0;
    logic [DIV_W-1:0]     cfg_divisor = '0;
    logic [NP-1:0]        path_done = '0;
    logic [8*NP-1:0]      path_sample = '0;
    logic                 sample_now;
    logic [2*NP-1:0]      path_mode;
    logic [DIV_W*NP-1:0]  path_divisor;
    logic [7:0]           mix_sample;
    logic                 mix_valid;
    logic                 timeout_err;

    soundpath_sched #(.NUM_PATHS(NP), .SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_mode     (cfg_mode),
        .cfg_divisor  (cfg_divisor),
        .path_done    (path_done),
        .path_sample  (path_sample),
        .sample_now   (sample_now),
        .path_mode    (path_mode),
        .path_divisor (path_divisor),
        .mix_sample   (mix_sample),
        .mix_valid    (mix_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {int j; int sel; int mode; int div;} wr_t;
    wr_t wr_q[$];
    int  sh_mode[NP], sh_div[NP], lv_mode[NP], lv_div[NP];
    int  dly[NP], samp[NP];
    bit  lvl[NP];
    int  mix_m;

    function automatic int mix_of(input int s);
`ifdef MIX_SAT_EN
        return (s > 255) ? 255 : s;
`else
        return s >> LG;
`endif
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NP; i++) begin
            sh_mode[i] = 0; sh_div[i] = 1; lv_mode[i] = 0; lv_div[i] = 1;
        end
        mix_m = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_strobe", sample_now, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_mix_sample", mix_sample, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_mode", path_mode, 0);
        for (int i = 0; i < NP; i++) check("rst_div", path_divisor[DIV_W*i +: DIV_W], 1);
    endtask

    // From a reset release at a negedge: the first strobe is SD+1 negedges later.
    task automatic sync_first();
        int n = 0;
        int mv = 0;
        do begin
            @(negedge clk);
            n++;
            mv += int'(mix_valid);
        end while (!sample_now && n < 400);
        check("first_strobe_delay", n, SD + 1);
        check("no_mix_after_rst", mv, 0);
    endtask

    task automatic plan_random();
        for (int i = 0; i < NP; i++) begin
            dly[i]  = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(1, 50));
            samp[i] = int'($urandom_range(0, 255));
            lvl[i]  = 1'($urandom);
        end
        repeat ($urandom_range(0, 3)) begin
            wr_t w;
            w.j = int'($urandom_range(1, SD - 1));
            w.sel = int'($urandom_range(0, NP - 1));
            w.mode = int'($urandom_range(0, 3));
            w.div = int'($urandom_range(0, (1 << DIV_W) - 1));
            wr_q.push_back(w);
        end
    endtask

    // Called positioned at the negedge where sample_now is visible; returns at the next one.
    task automatic run_round(input int abort_j);
        int  e, sum, exp_to, maxd, bad;
        bit  act[NP];
        sum = 0; exp_to = 0; maxd = 1; bad = 0;
        for (int i = 0; i < NP; i++) begin
            act[i] = lv_mode[i] != 0;
            if (act[i]) begin
                if (dly[i] > TO) exp_to = 1;
                else begin
                    sum += samp[i];
                    if (dly[i] > maxd) maxd = dly[i];
                end
            end
        end
        e = exp_to ? TO + 2 : maxd + 2;
        for (int j = 0; j < SD; j++) begin
            bit wrote = 0;
            if (j == 0) begin
                check("strobe", sample_now, 1);
                for (int i = 0; i < NP; i++) begin
                    check("live_mode", path_mode[2*i +: 2], lv_mode[i]);
                    check("live_div", path_divisor[DIV_W*i +: DIV_W], lv_div[i]);
                end
            end else if (j == e) begin
                mix_m = mix_of(sum);
                check("mix_valid", mix_valid, 1);
                check("mix_sample", mix_sample, mix_m);
                check("timeout_err", timeout_err, exp_to);
            end else begin
                bad += int'(mix_valid | timeout_err | sample_now);
            end
            if (j == SD - 1) begin
                check("mix_hold", mix_sample, mix_m);
                for (int i = 0; i < NP; i++) begin
                    check("pre_commit_mode", path_mode[2*i +: 2], lv_mode[i]);
                    check("pre_commit_div", path_divisor[DIV_W*i +: DIV_W], lv_div[i]);
                    lv_mode[i] = sh_mode[i];
                    lv_div[i]  = sh_div[i];
                end
            end
            if (j == abort_j) begin
                rst = 1'b1;
                #1;
                check_reset_outputs();
                path_done = '0;
                cfg_we = 1'b0;
                reset_model();
                wr_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                check("abort_no_mix", int'(bad), 0);
                sync_first();
                return;
            end
            for (int i = 0; i < NP; i++) begin
                bit d;
                logic [7:0] s;
                s = 8'($urandom);
                if (j == 0 || j >= e - 1 || !act[i]) d = 1'($urandom);
                else if (j == dly[i]) begin d = 1'b1; s = 8'(samp[i]); end
                else d = lvl[i] && j > dly[i];
                path_done[i] = d;
                path_sample[8*i +: 8] = s;
            end
            cfg_we = 1'b0;
            foreach (wr_q[k]) begin
                if (wr_q[k].j == j && !wrote) begin
                    wrote = 1;
                    cfg_we = 1'b1;
                    cfg_sel = LG'(wr_q[k].sel);
                    cfg_mode = 2'(wr_q[k].mode);
                    cfg_divisor = DIV_W'(wr_q[k].div);
                    sh_mode[wr_q[k].sel] = wr_q[k].mode;
                    sh_div[wr_q[k].sel]  = wr_q[k].div & ((1 << DIV_W) - 1);
                end
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
        wr_q.delete();
        check("stray_pulses", bad, 0);
    endtask

    function automatic wr_t mk(input int j, input int sel, input int mode, input int div);
        wr_t w;
        w.j = j; w.sel = sel; w.mode = mode; w.div = div;
        return w;
    endfunction

    initial begin
        reset_model();
        #1 rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sync_first();

        // Idle round; program all four paths mid-round (path 1: saw, 1000).
        for (int i = 0; i < NP; i++) begin dly[i] = 1; samp[i] = 0; lvl[i] = 0; end
        wr_q.push_back(mk(100, 0, 1, 500));
        wr_q.push_back(mk(101, 1, 2, 1000));
        wr_q.push_back(mk(102, 2, 3, 1500));
        wr_q.push_back(mk(103, 3, 1, 2000));
        run_round(-1);

        // Chord 40/80/120/160 with staggered dones; then turn paths 1 and 3 off.
        samp = '{40, 80, 120, 160};
        dly  = '{3, 5, 7, 9};
        wr_q.push_back(mk(150, 1, 0, 1000));
        wr_q.push_back(mk(151, 3, 0, 9));
        run_round(-1);

        // Path 0 done with 200, path 2 never: forced close; write during COMMIT.
        samp[0] = 200; dly[0] = 2; dly[2] = 1000;
        wr_q.push_back(mk(SD - 1, 0, 0, 77));
        run_round(-1);

        repeat (14) begin
            plan_random();
            run_round(-1);
        end

        // Make sure a path is active, then pull reset in the middle of WAIT.
        plan_random();
        wr_q.delete();
        wr_q.push_back(mk(50, 2, 1, 321));
        run_round(-1);
        for (int i = 0; i < NP; i++) dly[i] = 40;
        run_round(10);

        repeat (6) begin
            plan_random();
            run_round(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
